// File: rtl/sb_deserializer_fifo.sv
// sb_deserializer_fifo
//   Sideband receive deserializer. Collects LANES bits per qualified clock,
//   assembles WIDTH-bit words LSB-first and queues completed words in a
//   DEPTH-entry FIFO read through a ready/valid interface.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_data[LANES]       received bits, lane 0 is the low bit of each beat
//   in_en                beat qualifier
//   in_sync              with in_en, current beat is beat 0 of a new word
//   out_data[WIDTH]      FIFO head word (undefined while out_valid=0)
//   out_valid            FIFO non-empty
//   out_ready            consumer accepts head
//   fifo_level[LVL_W]    stored word count, 0..DEPTH
//   overflow             sticky: completed word dropped on a full FIFO
//   sync_err             sticky: partial word abandoned by in_sync
//   err_clr              clears both sticky flags
module sb_deserializer_fifo #(
  parameter int WIDTH  = 64,
  parameter int LANES  = 1,
  parameter int DEPTH  = 4,
  localparam int BEATS  = WIDTH / LANES,
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] in_data,
  input  logic             in_en,
  input  logic             in_sync,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  output logic             sync_err,
  input  logic             err_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BCNT_W-1:0] bcnt;
  logic [BCNT_W-1:0] idx;
  logic [WIDTH-1:0]  asm_reg;
  logic [WIDTH-1:0]  asm_next;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              word_done;
  logic              pop;
  logic              push;
  logic              drop;
  logic              sync_ev;

  // in_sync forces the current beat to slot 0; stale upper bits of the
  // abandoned word are overwritten before the new word can complete.
  always_comb begin
    idx      = in_sync ? '0 : bcnt;
    asm_next = asm_reg;
    asm_next[int'(idx) * LANES +: LANES] = in_data;
    word_done = in_en && (idx == BCNT_W'(BEATS - 1));
    sync_ev   = in_en && in_sync && (bcnt != '0);
    pop       = out_valid && out_ready;
    push      = word_done && ((fifo_level != LVL_W'(DEPTH)) || pop);
    drop      = word_done && !push;
  end

  assign out_valid = (fifo_level != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= '0;
    end else if (in_en) begin
      bcnt <= word_done ? '0 : idx + 1'b1;
    end
  end

  // Datapath storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (in_en) begin
      asm_reg <= asm_next;
    end
    if (push) begin
      mem[wr_ptr] <= asm_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // A fresh error event on the clearing edge keeps its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      overflow <= (overflow && !err_clr) || drop;
      sync_err <= (sync_err && !err_clr) || sync_ev;
    end
  end

endmodule
